// File: rtl/multicycle_ctrl.sv
// Main control FSM for the shared-ALU multicycle RV32I datapath: sequences each
// instruction through 3-5 steps, drives the datapath selects/enables and decodes the ALU op.
module multicycle_ctrl #(
    parameter bit ENABLE_UPPER = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       reg_write,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK,
        S_UPPER, S_TRAP
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic [3:0] w_alu_dec;
    logic       w_upper_op;
    logic       w_branch_ok;

    assign w_upper_op  = (op == OP_LUI) || (op == OP_AUIPC);
    assign w_branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    default:           w_next = (w_upper_op && ENABLE_UPPER) ? S_UPPER : S_TRAP;
                endcase
            end
            S_MEMADR:    w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:   w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:     w_next = S_FETCH;
            S_MEMWRITE:  w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:     w_next = S_ALUWB;
            S_EXECI:     w_next = S_ALUWB;
            S_ALUWB:     w_next = S_FETCH;
            S_BRANCH:    w_next = w_branch_ok ? S_FETCH : S_TRAP;
            S_JAL:       w_next = S_ALUWB;
            S_JALR:      w_next = S_JALR_LINK;
            S_JALR_LINK: w_next = S_ALUWB;
            S_UPPER:     w_next = S_ALUWB;
            S_TRAP:      w_next = S_TRAP;
            default:     w_next = S_FETCH;
        endcase
    end

    // The illegal flag is set on the transition into TRAP so it is already high in TRAP itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) r_illegal <= 1'b1;
        end
    end

    // addi never subtracts: funct7b5 only selects sub for register-register ops.
    always_comb begin
        w_alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  w_alu_dec = (funct7b5 && (r_state == S_EXECR)) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_dec = ALU_SLL;
            3'b010:  w_alu_dec = ALU_SLT;
            3'b011:  w_alu_dec = ALU_SLTU;
            3'b100:  w_alu_dec = ALU_XOR;
            3'b101:  w_alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_dec = ALU_OR;
            3'b111:  w_alu_dec = ALU_AND;
            default: w_alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE:         imm_src = 3'b001;
            OP_BR:            imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu_dec;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_alu_dec;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_JALR_LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_UPPER: begin
                alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
        // Async reset already forces FETCH; gating the strobes kills them in the same cycle.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a step-queue model of each instruction's sequence,
// checked every cycle, plus directed literal expectations for key cases.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam bit         UPPER_ON = 1'b1;
    // ALU code per funct3, funct3=7 in the top nibble: and, or, srl, xor, sltu, slt, sll, add
    localparam logic [31:0] ALU_TAB = {4'h2, 4'h3, 4'h8, 4'h4, 4'h6, 4'h5, 4'h7, 4'h0};

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;

    multicycle_ctrl #(.ENABLE_UPPER(UPPER_ON)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, a, b;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       rw, ill;
    } ctl_t;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE, T_EXECR, T_EXECI,
        T_ALUWB, T_BRANCH, T_JAL, T_JALR, T_LINK, T_UPPER, T_TRAP
    } step_t;

    step_t cur;
    step_t q[$];
    bit    m_ill;
    int    n_chk = 0, n_pass = 0;
    ctl_t  lit_val, lit_mask;
    string lit_name;
    int    tcnt;

    function automatic ctl_t model_ctl(input step_t s, input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic z, input logic mr,
                                       input logic rst, input bit ill);
        ctl_t c = '0;
        case (o)
            OP_STORE:         c.imm = 3'd1;
            OP_BR:            c.imm = 3'd2;
            OP_JAL:           c.imm = 3'd3;
            OP_LUI, OP_AUIPC: c.imm = 3'd4;
            default:          c.imm = 3'd0;
        endcase
        case (s)
            T_FETCH:    begin c.b = 2; c.rs = 2; c.irw = mr; c.pcw = mr; end
            T_DECODE:   begin c.a = 1; c.b = 1; end
            T_MEMADR:   begin c.a = 2; c.b = 1; end
            T_MEMREAD:  c.adr = 1;
            T_MEMWB:    begin c.rs = 1; c.rw = 1; end
            T_MEMWRITE: begin c.adr = 1; c.mw = 1; end
            T_EXECR, T_EXECI: begin
                c.a   = 2;
                c.b   = (s == T_EXECI) ? 2'd1 : 2'd0;
                c.alu = ALU_TAB[f3*4 +: 4];
                if (f3 == 3'd5 && f7) c.alu = 4'd9;
                if (f3 == 3'd0 && f7 && s == T_EXECR) c.alu = 4'd1;
            end
            T_ALUWB:    c.rw = 1;
            T_BRANCH:   begin c.a = 2; c.alu = 1; c.pcw = (f3 == 0) ? z : ((f3 == 1) ? !z : 1'b0); end
            T_JAL:      begin c.a = 1; c.b = 2; c.pcw = 1; end
            T_JALR:     begin c.a = 2; c.b = 1; c.rs = 2; c.pcw = 1; end
            T_LINK:     begin c.a = 1; c.b = 2; end
            T_UPPER:    begin c.b = 1; c.a = (o == OP_LUI) ? 2'd3 : 2'd1; end
            default: ;
        endcase
        if (rst) begin c.pcw = 0; c.irw = 0; c.mw = 0; c.rw = 0; end
        c.ill = ill;
        return c;
    endfunction

    task automatic model_reset();
        cur = T_FETCH;
        q.delete();
        m_ill = 0;
    endtask

    task automatic plan();
        q.delete();
        q.push_back(T_DECODE);
        case (op)
            OP_LOAD:  begin q.push_back(T_MEMADR); q.push_back(T_MEMREAD); q.push_back(T_MEMWB); end
            OP_STORE: begin q.push_back(T_MEMADR); q.push_back(T_MEMWRITE); end
            OP_R:     begin q.push_back(T_EXECR); q.push_back(T_ALUWB); end
            OP_I:     begin q.push_back(T_EXECI); q.push_back(T_ALUWB); end
            OP_BR:    begin q.push_back(T_BRANCH); if (funct3 > 3'd1) q.push_back(T_TRAP); end
            OP_JAL:   begin q.push_back(T_JAL); q.push_back(T_ALUWB); end
            OP_JALR:  begin q.push_back(T_JALR); q.push_back(T_LINK); q.push_back(T_ALUWB); end
            OP_LUI, OP_AUIPC: begin
                if (UPPER_ON) begin q.push_back(T_UPPER); q.push_back(T_ALUWB); end
                else q.push_back(T_TRAP);
            end
            default:  q.push_back(T_TRAP);
        endcase
    endtask

    task automatic model_tick();
        if (reset) model_reset();
        else begin
            case (cur)
                T_TRAP: ;
                T_FETCH: if (mem_ready) begin plan(); cur = q.pop_front(); end
                T_MEMREAD, T_MEMWRITE: if (mem_ready) cur = (q.size() == 0) ? T_FETCH : q.pop_front();
                default: cur = (q.size() == 0) ? T_FETCH : q.pop_front();
            endcase
            if (cur == T_TRAP) m_ill = 1;
        end
    endtask

    always @(negedge clk) begin
        ctl_t e, a;
        a = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
             imm_src, alu_control, reg_write, illegal};
        e = model_ctl(cur, op, funct3, funct7b5, zero, mem_ready, reset, m_ill);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL model t=%0t step=%s got %b need %b", $time, cur.name(), a, e);
        if (lit_mask != '0) begin
            n_chk++;
            if (((a ^ lit_val) & lit_mask) === '0) n_pass++;
            else $display("FAIL %s got %b need %b (mask %b)", lit_name, a, lit_val, lit_mask);
        end
    end

    task automatic at(input string nm);
        lit_name = nm;
        lit_mask = '0;
        lit_val  = '0;
    endtask

    task automatic lit(input string f, input int unsigned v);
        case (f)
            "pcw": begin lit_mask.pcw = '1; lit_val.pcw = v[0]; end
            "adr": begin lit_mask.adr = '1; lit_val.adr = v[0]; end
            "mw":  begin lit_mask.mw  = '1; lit_val.mw  = v[0]; end
            "irw": begin lit_mask.irw = '1; lit_val.irw = v[0]; end
            "rs":  begin lit_mask.rs  = '1; lit_val.rs  = v[1:0]; end
            "a":   begin lit_mask.a   = '1; lit_val.a   = v[1:0]; end
            "b":   begin lit_mask.b   = '1; lit_val.b   = v[1:0]; end
            "imm": begin lit_mask.imm = '1; lit_val.imm = v[2:0]; end
            "alu": begin lit_mask.alu = '1; lit_val.alu = v[3:0]; end
            "rw":  begin lit_mask.rw  = '1; lit_val.rw  = v[0]; end
            default: begin lit_mask.ill = '1; lit_val.ill = v[0]; end
        endcase
    endtask

    // Inputs change just after the rising edge; outputs are compared on the falling edge.
    task automatic step(input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        if (reset) model_reset();
        @(negedge clk);
        @(posedge clk);
        model_tick();
        #1;
        lit_mask = '0;
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && cur != T_FETCH; i++) step(1'b1, 1'b0);
    endtask

    task automatic pick_instr();
        int unsigned k;
        k        = $urandom_range(0, 10);
        funct3   = 3'($urandom_range(0, 7));
        funct7b5 = 1'($urandom_range(0, 1));
        case (k)
            0: op = OP_LOAD;
            1: op = OP_STORE;
            2, 10: op = OP_R;
            3: op = OP_I;
            4: begin op = OP_BR; funct3 = 3'($urandom_range(0, 2)); end
            5: op = OP_JAL;
            6: op = OP_JALR;
            7: op = OP_LUI;
            8: op = OP_AUIPC;
            default: op = 7'($urandom_range(0, 127));
        endcase
    endtask

    initial begin
        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        lit_mask = '0; lit_val = '0; lit_name = "";
        model_reset();
        #1;
        at("reset"); lit("irw", 0); lit("pcw", 0); lit("rw", 0); lit("mw", 0); lit("ill", 0);
        lit("b", 2); lit("rs", 2); lit("a", 0); lit("adr", 0); step(1, 0);
        reset = 1'b0;

        instr(OP_R, 3'd0, 1'b0);
        at("add.fetch");  lit("irw", 1); lit("pcw", 1); lit("rw", 0); step(1, 0);
        at("add.decode"); lit("a", 1); lit("b", 1); lit("rw", 0); step(1, 0);
        at("add.execr");  lit("a", 2); lit("b", 0); lit("alu", 0); lit("rw", 0); step(1, 0);
        at("add.aluwb");  lit("rw", 1); lit("rs", 0); step(1, 0);

        instr(OP_R, 3'd0, 1'b1);
        step(1, 0); step(1, 0);
        at("sub.execr"); lit("alu", 1); step(1, 0);
        step(1, 0);

        instr(OP_I, 3'd0, 1'b1);
        step(1, 0); step(1, 0);
        at("addi.execi"); lit("alu", 0); lit("b", 1); step(1, 0);
        step(1, 0);

        instr(OP_LOAD, 3'd2, 1'b0);
        at("lw.c1"); lit("irw", 1); step(1, 0);
        at("lw.c2"); lit("rw", 0); lit("imm", 0); step(1, 0);
        at("lw.c3"); lit("a", 2); lit("b", 1); step(1, 0);
        at("lw.c4"); lit("adr", 1); lit("rw", 0); step(0, 0);
        at("lw.c5"); lit("adr", 1); lit("rw", 0); step(0, 0);
        at("lw.c6"); lit("adr", 1); lit("rw", 0); step(1, 0);
        at("lw.c7"); lit("rw", 1); lit("rs", 1); step(1, 0);
        at("lw.next"); lit("irw", 1); lit("rw", 0);

        for (int k = 0; k < 4; k++) begin
            instr(OP_BR, (k >= 2) ? 3'd1 : 3'd0, 1'b0);
            step(1, 0); step(1, 0);
            at("branch"); lit("pcw", (k == 0 || k == 3) ? 1 : 0); lit("alu", 1); lit("imm", 2);
            step(1, (k == 0 || k == 2) ? 1'b1 : 1'b0);
        end

        instr(OP_JALR, 3'd0, 1'b0);
        step(1, 0); step(1, 0);
        at("jalr.jalr");  lit("pcw", 1); lit("rs", 2); lit("a", 2); lit("b", 1); step(1, 0);
        at("jalr.link");  lit("a", 1); lit("b", 2); lit("rw", 0); lit("pcw", 0); step(1, 0);
        at("jalr.aluwb"); lit("rw", 1); step(1, 0);

        instr(OP_LUI, 3'd0, 1'b0);
        step(1, 0); step(1, 0);
        at("lui.upper"); lit("a", 3); lit("b", 1); lit("imm", 4); step(1, 0);
        at("lui.aluwb"); lit("rw", 1); step(1, 0);

        instr(OP_STORE, 3'd2, 1'b0);
        step(1, 0); step(1, 0);
        at("sw.memadr");   lit("imm", 1); lit("a", 2); step(1, 0);
        at("sw.memwrite"); lit("mw", 1); lit("adr", 1); step(0, 0);
        reset = 1'b1;
        at("sw.reset");    lit("mw", 0); lit("rw", 0); lit("adr", 0); step(0, 0);
        reset = 1'b0;
        at("sw.refetch");  lit("irw", 1); lit("pcw", 1); lit("ill", 0); step(1, 0);
        drain();

        instr(OP_BR, 3'd4, 1'b0);
        step(1, 0); step(1, 0);
        at("bad.branch"); lit("pcw", 0); lit("ill", 0); step(1, 1);
        at("bad.trap");   lit("ill", 1); lit("pcw", 0); step(1, 0);
        at("bad.hold");   lit("ill", 1); lit("irw", 0); step(1, 0);
        reset = 1'b1; step(1, 0); reset = 1'b0;

        instr(7'b0000000, 3'd0, 1'b0);
        step(1, 0);
        at("op0.decode"); lit("ill", 0); step(1, 0);
        at("op0.trap");   lit("ill", 1); lit("pcw", 0); step(1, 0);
        at("op0.hold");   lit("ill", 1); lit("rw", 0); lit("irw", 0); step(1, 0);
        step(1, 0);
        reset = 1'b1;
        at("op0.reset");  lit("ill", 0); step(1, 0);
        reset = 1'b0;

        tcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (cur == T_FETCH) pick_instr();
            tcnt = (cur == T_TRAP) ? tcnt + 1 : 0;
            if (tcnt > 3 || $urandom_range(0, 249) == 0) reset = 1'b1;
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main FSM that sequences the shared-ALU multicycle RV32I datapath. It is the successor to the single-cycle core, with one memory port for instructions and data and one ALU.
- Each instruction is broken into 3–5 steps. The block drives all mux selects, write enables and the ALU op.
- It also decodes funct3/funct7 into the ALU code and stalls on a memory-ready handshake.

Parameters:
- ENABLE_UPPER, 1: 1 = lui/auipc supported; 0 = opcodes 0110111/0010111 go to TRAP.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag (valid in BRANCH)
- mem_ready  in  1  memory returns data / accepts write this cycle
- pc_write  out  1  PC register load
- adr_src  out  1  memory address: 0 = pc, 1 = result
- mem_write  out  1  data memory write strobe
- ir_write  out  1  load IR and old_pc
- result_src  out  2  00 alu_out reg, 01 mem data reg, 10 alu_result (direct)
- alu_src_a  out  2  00 pc, 01 old_pc, 10 A reg (rs1), 11 zero
- alu_src_b  out  2  00 B reg (rs2), 01 imm_ext, 10 const 4
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
- reg_write  out  1  register file write
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk.
  - State goes to FETCH and illegal is cleared to 0.
  - While reset is high, mem_write = reg_write = pc_write = ir_write = 0. All selects take their FETCH values.
- Defaults: all enables are 0 and selects are 00 unless listed below.
- imm_src is a pure decode of op, valid in every state. Unknown op gives 000.

State actions and transitions:
- FETCH: adr_src 0; a 00; b 10; add; result_src 10.
  - ir_write and pc_write assert only when mem_ready = 1.
  - Stay in FETCH while mem_ready = 0, else go to DECODE.
- DECODE: a 01; b 01; add, which pre-computes the branch/jal target into alu_out.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - lui/auipc → UPPER
    - anything else → TRAP
- MEMADR: a 10; b 01; add. Go to MEMREAD if op = 0000011, else MEMWRITE.
- MEMREAD: adr_src 1; result_src 00. Hold while mem_ready = 0, then go to MEMWB.
- MEMWB: result_src 01; reg_write. Go to FETCH.
- MEMWRITE: adr_src 1; result_src 00; mem_write held high until mem_ready = 1. Then go to FETCH.
- EXECR: a 10; b 00; alu_control from funct3. Go to ALUWB.
  - funct3 000 gives sub when funct7b5 = 1, else add.
  - funct3 101 gives sra when funct7b5 = 1, else srl.
- EXECI: a 10; b 01; same decode, except funct7b5 is honoured only for funct3 = 101 (addi never subtracts). Go to ALUWB.
- ALUWB: result_src 00; reg_write. Go to FETCH.
- BRANCH: a 10; b 00; sub; result_src 00. Go to FETCH.
  - pc_write = zero for funct3 000 (beq) and !zero for 001 (bne).
  - Any other funct3 goes to TRAP instead, with pc_write = 0.
- JAL: a 01; b 10; add; result_src 00; pc_write. Go to ALUWB, which writes old_pc+4.
- JALR: a 10; b 01; add; result_src 10; pc_write. Go to JALR_LINK.
- JALR_LINK: a 01; b 10; add. Go to ALUWB. Using the A reg latched at DECODE keeps rd == rs1 correct.
- UPPER: b 01; add; a 11 for lui, a 01 for auipc. Go to ALUWB.
- TRAP: illegal = 1; all enables 0. Terminal until reset.

Cycle counts with mem_ready always 1:
- beq/bne: 3
- R, I, sw, jal, lui, auipc: 4
- lw, jalr: 5

Boundary rules:
- Each mem_ready wait cycle adds exactly one cycle and holds all outputs stable.
- Reset asserted mid-instruction aborts it immediately, with no partial reg_write or mem_write after reset rises.

Test Plan:
- add x3,x1,x2, mem_ready = 1 → states FETCH, DECODE, EXECR, ALUWB. alu_control 0000 in EXECR; reg_write high only in cycle 4.
- sub (funct7b5 = 1) vs addi with instr[30] = 1 → EXECR alu_control 0001; EXECI alu_control 0000.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; adr_src = 1 held during the stall; reg_write in MEMWB only.
- beq with zero = 1 → pc_write = 1 in BRANCH. Repeat with zero = 0 → pc_write = 0. bne inverts both cases. funct3 = 100 → TRAP, illegal = 1.
- jalr x1,0(x1) → pc_write in JALR with result_src 10. JALR_LINK then ALUWB: alu_src_a 01, alu_src_b 10, reg_write.
- op = 0000000 → TRAP; illegal stays 1 until reset. Assert reset mid-MEMWRITE → mem_write drops the same cycle; state returns to FETCH.
